// File: rtl/arduino_io_pkg.sv
// Shared types and constants for the Arduino byte-bus to block-RAM bridge.
package arduino_io_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    CLK_HI,
    CLK_LO,
    CAPTURE,
    CLEANUP,
    RELEASE
  } state_e;

  localparam logic [7:0] READ_FILL = 8'hFF;

  // Whole bytes needed to carry a bank select plus an address.
  function automatic int hdr_bytes(input int sel_w, input int addr_w);
    return (sel_w + addr_w + 7) / 8;
  endfunction

endpackage

// File: rtl/arduino_io_bridge_if.sv
// Arduino pin bundle plus the shared/per-bank block-RAM port-A signals.
interface arduino_io_bridge_if #(
  parameter int NUM_BANKS = 4,
  parameter int ADDR_W    = 14
);
  logic [7:0]             arduino_datain;
  logic                   arduino_clock;
  logic                   arduino_commit;
  logic                   arduino_readwrite;
  logic                   arduino_autoinc;
  logic [7:0]             arduino_dataout;
  logic                   arduino_busy;
  logic [NUM_BANKS-1:0]   mem_clk;
  logic [NUM_BANKS-1:0]   mem_ce;
  logic [NUM_BANKS-1:0]   mem_oce;
  logic [NUM_BANKS-1:0]   mem_wre;
  logic [ADDR_W-1:0]      mem_ad;
  logic [7:0]             mem_din;
  logic [NUM_BANKS*8-1:0] mem_dout;

  // master: the Arduino and the RAM banks; slave: the bridge between them
  modport master (
    output arduino_datain, arduino_clock, arduino_commit, arduino_readwrite,
           arduino_autoinc, mem_dout,
    input  arduino_dataout, arduino_busy, mem_clk, mem_ce, mem_oce, mem_wre,
           mem_ad, mem_din
  );

  modport slave (
    input  arduino_datain, arduino_clock, arduino_commit, arduino_readwrite,
           arduino_autoinc, mem_dout,
    output arduino_dataout, arduino_busy, mem_clk, mem_ce, mem_oce, mem_wre,
           mem_ad, mem_din
  );
endinterface

// File: rtl/arduino_io_sync.sv
// Multi-flop synchroniser for an asynchronous strobe with a one-cycle rising-edge pulse.
module arduino_io_sync #(
  parameter int STAGES = 2
) (
  input  logic sysclk,
  input  logic arduino_reset,
  input  logic async_in,
  output logic level,
  output logic rise
);
  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge sysclk or posedge arduino_reset) begin
    if (arduino_reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_in};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
endmodule

// File: rtl/arduino_io_bridge.sv
// Arduino byte-bus to block-RAM bridge: strobe sync, framed headers, auto-increment
// pointer and a busy handshake around a fixed seven-state access sequence.
module arduino_io_bridge
  import arduino_io_pkg::*;
#(
  parameter int NUM_BANKS   = 4,
  parameter int ADDR_W      = 14,
  parameter int SYNC_STAGES = 2
) (
  input logic                sysclk,
  input logic                arduino_reset,
  arduino_io_bridge_if.slave bus
);
  localparam int SEL_W     = $clog2(NUM_BANKS);
  localparam int HDR_BYTES = hdr_bytes(SEL_W, ADDR_W);
  localparam int HDR_W     = HDR_BYTES * 8;
  localparam int FRAME_W   = (HDR_BYTES + 1) * 8;

  state_e               state, state_nxt;
  logic [FRAME_W-1:0]   shift_q, shift_nxt;
  logic [HDR_W-1:0]     hdr;
  logic [SEL_W-1:0]     sel, bank_q, ptr_bank;
  logic [ADDR_W-1:0]    addr, ptr_addr;
  logic [NUM_BANKS-1:0] sel_hot;
  logic                 sel_ok, ok_q, rw_q;
  logic [7:0]           rd_byte;
  logic                 clk_rise, clk_level_unused, commit_level, commit_rise;

  arduino_io_sync #(.STAGES(SYNC_STAGES)) u_clk_sync (
    .sysclk(sysclk), .arduino_reset(arduino_reset), .async_in(bus.arduino_clock),
    .level(clk_level_unused), .rise(clk_rise)
  );

  arduino_io_sync #(.STAGES(SYNC_STAGES)) u_commit_sync (
    .sysclk(sysclk), .arduino_reset(arduino_reset), .async_in(bus.arduino_commit),
    .level(commit_level), .rise(commit_rise)
  );

  // A byte strobed in the same cycle as the commit edge is part of the frame.
  always_comb begin
    shift_nxt = shift_q;
    if (state == IDLE && clk_rise) shift_nxt = {shift_q[FRAME_W-9:0], bus.arduino_datain};
  end

  assign hdr     = bus.arduino_readwrite ? shift_nxt[FRAME_W-1:8] : shift_nxt[HDR_W-1:0];
  assign sel     = bus.arduino_autoinc ? ptr_bank : hdr[SEL_W+ADDR_W-1:ADDR_W];
  assign addr    = bus.arduino_autoinc ? ptr_addr : hdr[ADDR_W-1:0];
  assign sel_ok  = (32'(sel) < NUM_BANKS);
  assign sel_hot = sel_ok ? (NUM_BANKS'(1) << sel) : '0;

  always_comb begin
    rd_byte = READ_FILL;
    for (int k = 0; k < NUM_BANKS; k++)
      if (ok_q && bank_q == SEL_W'(k)) rd_byte = bus.mem_dout[k*8 +: 8];
  end

  always_comb begin
    // NOTE: default first so every path assigns state_nxt; a missing branch would infer a latch.
    state_nxt = state;
    unique case (state)
      IDLE:    if (commit_rise) state_nxt = SETUP;
      SETUP:   state_nxt = CLK_HI;
      CLK_HI:  state_nxt = CLK_LO;
      CLK_LO:  state_nxt = CAPTURE;
      CAPTURE: state_nxt = CLEANUP;
      CLEANUP: state_nxt = RELEASE;
      RELEASE: if (!commit_level) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sysclk or posedge arduino_reset) begin
    if (arduino_reset) state <= IDLE;
    else               state <= state_nxt;
  end

  // Strobes are registered so each one is visible during the state it belongs to.
  always_ff @(posedge sysclk or posedge arduino_reset) begin
    if (arduino_reset) begin
      shift_q             <= '0;
      rw_q                <= 1'b0;
      ok_q                <= 1'b0;
      bank_q              <= '0;
      ptr_bank            <= '0;
      ptr_addr            <= '0;
      bus.arduino_dataout <= '0;
      bus.mem_clk         <= '0;
      bus.mem_ce          <= '0;
      bus.mem_oce         <= '0;
      bus.mem_wre         <= '0;
      bus.mem_ad          <= '0;
      bus.mem_din         <= '0;
    end else begin
      // NOTE: non-blocking throughout so every flop samples pre-edge values.
      shift_q <= shift_nxt;
      unique case (state)
        IDLE: if (commit_rise) begin
          rw_q        <= bus.arduino_readwrite;
          ok_q        <= sel_ok;
          bank_q      <= sel;
          bus.mem_ad  <= addr;
          if (bus.arduino_readwrite) bus.mem_din <= shift_nxt[7:0];
          bus.mem_ce  <= sel_hot;
          bus.mem_oce <= bus.arduino_readwrite ? '0 : sel_hot;
          bus.mem_wre <= bus.arduino_readwrite ? sel_hot : '0;
        end
        SETUP:  bus.mem_clk <= bus.mem_ce;
        CLK_HI: bus.mem_clk <= '0;
        CAPTURE: begin
          if (!rw_q) bus.arduino_dataout <= rd_byte;
          ptr_bank    <= bank_q;
          ptr_addr    <= bus.mem_ad + ADDR_W'(1);
          bus.mem_ce  <= '0;
          bus.mem_oce <= '0;
          bus.mem_wre <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.arduino_busy = (state != IDLE);
endmodule

// File: tb/tb_arduino_io_bridge.sv
// Scoreboard bench: a 4-bank bridge with RAM models, plus a 3-bank build for out-of-range selects.
module tb_arduino_io_bridge;
  typedef struct {
    bit          wr;
    int          bank;
    logic [13:0] addr;
    logic [7:0]  data;
  } txn_t;

  logic       sysclk = 1'b0;
  logic       arduino_reset;
  logic [7:0] datain;
  logic       aclk, commit, rw, ai;
  int         n_checks = 0;
  int         n_err = 0;
  txn_t       exp_q[$];

  always #5 sysclk = ~sysclk;

  arduino_io_bridge_if #(.NUM_BANKS(4), .ADDR_W(14)) b4 ();
  arduino_io_bridge_if #(.NUM_BANKS(3), .ADDR_W(14)) b3 ();

  assign b4.arduino_datain    = datain;
  assign b4.arduino_clock     = aclk;
  assign b4.arduino_commit    = commit;
  assign b4.arduino_readwrite = rw;
  assign b4.arduino_autoinc   = ai;
  assign b3.arduino_datain    = datain;
  assign b3.arduino_clock     = aclk;
  assign b3.arduino_commit    = commit;
  assign b3.arduino_readwrite = rw;
  assign b3.arduino_autoinc   = ai;
  assign b3.mem_dout          = 24'h3C_C3_5A;

  arduino_io_bridge #(.NUM_BANKS(4), .ADDR_W(14), .SYNC_STAGES(2)) dut4 (
    .sysclk(sysclk), .arduino_reset(arduino_reset), .bus(b4)
  );

  arduino_io_bridge #(.NUM_BANKS(3), .ADDR_W(14), .SYNC_STAGES(2)) dut3 (
    .sysclk(sysclk), .arduino_reset(arduino_reset), .bus(b3)
  );

  for (genvar k = 0; k < 4; k++) begin : g_bank
    logic [7:0] m [16384];
    logic [7:0] rd;
    initial begin
      rd = 8'h00;
      for (int a = 0; a < 16384; a++) m[a] = 8'h00;
    end
    always @(posedge b4.mem_clk[k]) begin
      if (b4.mem_ce[k]) begin
        if (b4.mem_wre[k]) m[b4.mem_ad] <= b4.mem_din;
        if (b4.mem_oce[k]) rd <= m[b4.mem_ad];
      end
    end
    assign b4.mem_dout[k*8 +: 8] = rd;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  // Monitor: follows each busy window of the 4-bank bridge against the queued expectation.
  int         mon_cyc = 0;
  bit         cur_ok = 1'b0;
  txn_t       cur;
  logic [3:0] hot;
  logic [3:0] one4 = 4'b0001;

  always @(negedge sysclk) begin
    if (arduino_reset) begin
      mon_cyc = 0;
    end else if (mon_cyc == 0) begin
      if (b4.arduino_busy) begin
        mon_cyc = 1;
        if (exp_q.size() == 0) begin
          cur_ok = 1'b0;
          check("unexpected_txn", 32'd1, 32'd0);
        end else begin
          cur    = exp_q.pop_front();
          cur_ok = 1'b1;
          hot    = one4 << cur.bank;
          check($sformatf("setup_ce b%0d", cur.bank), b4.mem_ce, hot);
          check("setup_wre", b4.mem_wre, cur.wr ? hot : 4'b0);
          check("setup_oce", b4.mem_oce, cur.wr ? 4'b0 : hot);
          check("setup_ad", b4.mem_ad, cur.addr);
          if (cur.wr) check("setup_din", b4.mem_din, cur.data);
        end
      end
    end else begin
      mon_cyc++;
      if (!b4.arduino_busy) mon_cyc = 0;
      else if (cur_ok) begin
        case (mon_cyc)
          2: check("clk_hi", b4.mem_clk, hot);
          3: check("clk_lo", b4.mem_clk, 4'b0);
          5: begin
            check("cleanup_strobes", {b4.mem_ce, b4.mem_oce, b4.mem_wre}, 12'h0);
            if (!cur.wr)
              check($sformatf("rd_data b%0d a%0h", cur.bank, cur.addr), b4.arduino_dataout, cur.data);
          end
          default: ;
        endcase
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge sysclk);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] b);
    datain = b;
    tick(2);
    aclk = 1'b1;
    tick(5);
    aclk = 1'b0;
    tick(5);
  endtask

  task automatic wait_busy(input logic lvl, input string name);
    int n = 0;
    while (b4.arduino_busy !== lvl && n < 40) begin
      @(negedge sysclk);
      n++;
    end
    check(name, b4.arduino_busy, lvl);
  endtask

  task automatic push(input bit wr, input int bank, input logic [13:0] addr, input logic [7:0] data);
    txn_t t;
    t.wr = wr; t.bank = bank; t.addr = addr; t.data = data;
    exp_q.push_back(t);
  endtask

  task automatic run_txn(input bit wr, input bit inc, input bit watch3);
    int n = 0;
    rw = wr;
    ai = inc;
    tick(1);
    commit = 1'b1;
    wait_busy(1'b1, "busy_rise");
    commit = 1'b0;
    while (b4.arduino_busy === 1'b1 && n < 40) begin
      if (watch3)
        check("oob_strobes", {b3.mem_clk, b3.mem_ce, b3.mem_oce, b3.mem_wre}, 12'h0);
      @(negedge sysclk);
      n++;
    end
    check("busy_fall", b4.arduino_busy, 1'b0);
    if (watch3) check("oob_read_fill", b3.arduino_dataout, 8'hFF);
    tick(3);
  endtask

  initial begin
    datain = 8'h00; aclk = 1'b0; commit = 1'b0; rw = 1'b0; ai = 1'b0;
    arduino_reset = 1'b0;
    #1 arduino_reset = 1'b1;
    #1;
    check("rst_busy", b4.arduino_busy, 1'b0);
    check("rst_strobes", {b4.mem_clk, b4.mem_ce, b4.mem_oce, b4.mem_wre}, 16'h0);
    check("rst_dataout", b4.arduino_dataout, 8'h00);
    tick(3);
    arduino_reset = 1'b0;
    tick(3);

    // 1: write then read bank 0 addr 0x0123
    send_byte(8'h01); send_byte(8'h23); send_byte(8'hA5);
    push(1'b1, 0, 14'h0123, 8'hA5); run_txn(1'b1, 1'b0, 1'b0);
    send_byte(8'h01); send_byte(8'h23);
    push(1'b0, 0, 14'h0123, 8'hA5); run_txn(1'b0, 1'b0, 1'b0);

    // 2: address wrap inside bank 3
    send_byte(8'hFF); send_byte(8'hFF); send_byte(8'h5A);
    push(1'b1, 3, 14'h3FFF, 8'h5A); run_txn(1'b1, 1'b0, 1'b0);
    send_byte(8'h77);
    push(1'b1, 3, 14'h0000, 8'h77); run_txn(1'b1, 1'b1, 1'b0);
    send_byte(8'hFF); send_byte(8'hFF);
    push(1'b0, 3, 14'h3FFF, 8'h5A); run_txn(1'b0, 1'b0, 1'b0);
    send_byte(8'hC0); send_byte(8'h00);
    push(1'b0, 3, 14'h0000, 8'h77); run_txn(1'b0, 1'b0, 1'b0);

    // 3: preload bank 1 then an auto-increment read burst
    send_byte(8'h40); send_byte(8'h10); send_byte(8'h10);
    push(1'b1, 1, 14'h0010, 8'h10); run_txn(1'b1, 1'b0, 1'b0);
    for (int i = 1; i < 4; i++) begin
      send_byte(8'h10 + 8'(i));
      push(1'b1, 1, 14'h0010 + 14'(i), 8'h10 + 8'(i)); run_txn(1'b1, 1'b1, 1'b0);
    end
    send_byte(8'h40); send_byte(8'h10);
    push(1'b0, 1, 14'h0010, 8'h10); run_txn(1'b0, 1'b0, 1'b0);
    for (int i = 1; i < 4; i++) begin
      push(1'b0, 1, 14'h0010 + 14'(i), 8'h10 + 8'(i)); run_txn(1'b0, 1'b1, 1'b0);
    end

    // 4: byte strobe while busy is ignored; busy held while commit stays high
    send_byte(8'h01); send_byte(8'h23);
    push(1'b0, 0, 14'h0123, 8'hA5);
    rw = 1'b0; ai = 1'b0; tick(1);
    commit = 1'b1;
    wait_busy(1'b1, "hold_busy_rise");
    datain = 8'hEE; aclk = 1'b1; tick(3); aclk = 1'b0;
    tick(20);
    check("busy_held", b4.arduino_busy, 1'b1);
    commit = 1'b0;
    wait_busy(1'b0, "hold_busy_fall");
    tick(3);
    push(1'b0, 0, 14'h0123, 8'hA5); run_txn(1'b0, 1'b0, 1'b0);

    // 5: reset during CLK_HI of a write clears outputs and the pointer
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h3C);
    push(1'b1, 0, 14'h0000, 8'h3C); run_txn(1'b1, 1'b0, 1'b0);
    send_byte(8'h82); send_byte(8'h00); send_byte(8'h99);
    push(1'b1, 2, 14'h0200, 8'h99);
    rw = 1'b1; ai = 1'b0; tick(1);
    commit = 1'b1;
    wait_busy(1'b1, "abort_busy_rise");
    @(posedge sysclk); #1;
    check("pre_rst_clk_hi", b4.mem_clk, 4'b0100);
    #1 arduino_reset = 1'b1;
    commit = 1'b0;
    #1;
    check("midop_rst_busy", b4.arduino_busy, 1'b0);
    check("midop_rst_strobes", {b4.mem_clk, b4.mem_ce, b4.mem_oce, b4.mem_wre}, 16'h0);
    check("midop_rst_ad", b4.mem_ad, 14'h0);
    check("midop_rst_din", b4.mem_din, 8'h00);
    check("midop_rst_dataout", b4.arduino_dataout, 8'h00);
    tick(3);
    arduino_reset = 1'b0;
    tick(3);
    push(1'b0, 0, 14'h0000, 8'h3C); run_txn(1'b0, 1'b1, 1'b0);

    // 6: bank select 3 on the 3-bank build is out of range
    send_byte(8'hC0); send_byte(8'h05);
    push(1'b0, 3, 14'h0005, 8'h00); run_txn(1'b0, 1'b0, 1'b1);

    tick(5);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/arduino_io_bridge.md
Name: arduino_io_bridge

Overview:
- Parametrised successor to the Arduino byte-bus memory bridge; sits between the Arduino pins and NUM_BANKS single-port block-RAM ports (port A of the dual-port banks).
- Adds:
  - sysclk-domain synchronisation of the Arduino strobes.
  - A busy handshake.
  - An auto-increment address pointer for burst reads and writes.
  - Safe handling of out-of-range bank selects.

Parameters:
- NUM_BANKS, 4, number of memory banks (2..16).
- ADDR_W, 14, address width per bank.
- SYNC_STAGES, 2, flops in each strobe synchroniser (min 2).
- Derived (localparam, not overridable):
  - SEL_W = clog2(NUM_BANKS).
  - HDR_BYTES = ceil((SEL_W+ADDR_W)/8).
  - FRAME_W = (HDR_BYTES+1)*8.

Ports:
- sysclk  in  1  system clock; all logic on rising edge.
- arduino_reset  in  1  asynchronous, active-high reset.
- arduino_datain  in  8  byte presented by Arduino.
- arduino_clock  in  1  byte strobe, asynchronous to sysclk.
- arduino_commit  in  1  transaction request, asynchronous.
- arduino_readwrite  in  1  1 = write, 0 = read; sampled at commit detect.
- arduino_autoinc  in  1  1 = use internal pointer instead of header; sampled at commit detect.
- arduino_dataout  out  8  read result, held until next read.
- arduino_busy  out  1  high while a transaction is in progress.
- mem_clk  out  NUM_BANKS  per-bank memory clock.
- mem_ce  out  NUM_BANKS  per-bank chip enable.
- mem_oce  out  NUM_BANKS  per-bank output-clock enable.
- mem_wre  out  NUM_BANKS  per-bank write enable.
- mem_ad  out  ADDR_W  shared address to all banks.
- mem_din  out  8  shared write data.
- mem_dout  in  NUM_BANKS*8  bank k read data at bits [8k+7:8k].

Behaviour:
- Reset (asynchronous, immediate):
  - All mem_* outputs and arduino_dataout become 0; busy = 0.
  - Shift register, pointer and synchronisers cleared; state = IDLE.
  - Reset mid-transaction aborts it with no partial write completing after assertion.
- Strobe sync: arduino_clock and arduino_commit each pass SYNC_STAGES flops; edge detect compares with one further flop.
- Byte shift: on a synchronised arduino_clock rising edge while state = IDLE, the FRAME_W shift register shifts left 8 and loads arduino_datain into bits [7:0]. Edges outside IDLE are ignored.
- Frame layout:
  - Read header = bits [HDR_BYTES*8-1:0].
  - Write header = bits [FRAME_W-1:8]; write data = bits [7:0].
  - Within a header, the bank select is bits [SEL_W+ADDR_W-1:ADDR_W] and the address is [ADDR_W-1:0]; higher bits are ignored.
- Autoinc: the header is ignored; bank/address come from the pointer. Write data is still bits [7:0].
- FSM, one state per cycle, except IDLE and RELEASE, which wait:
  - IDLE: on commit rising edge, latch rw, autoinc, bank and address (including any byte shifted that same cycle); go to SETUP; busy = 1 from this edge.
  - SETUP: drive mem_ad, plus mem_din for writes; assert ce plus oce (read) or wre (write) for the selected bank only.
  - CLK_HI: mem_clk of the selected bank = 1.
  - CLK_LO: mem_clk = 0.
  - CAPTURE:
    - Read: arduino_dataout <= the selected bank's mem_dout slice.
    - Write: no action.
    - Both: pointer <= {bank, address+1}; the address wraps modulo 2^ADDR_W within the same bank, and the bank is never incremented.
  - CLEANUP: all ce/oce/wre = 0.
  - RELEASE: wait until synchronised commit = 0, then go to IDLE with busy = 0.
- Timing: commit edge detected at cycle N gives SETUP at N+1, CLK_HI at N+2, CLK_LO at N+3 and CAPTURE at N+4 (dataout valid N+5). busy falls no earlier than N+7.
- Out-of-range bank (select ≥ NUM_BANKS):
  - The FSM sequences normally, but no mem strobes are asserted.
  - A read returns 8'hFF.
  - The pointer still updates.
- Only one bank's strobes are ever high at a time; mem_ad and mem_din hold their last values between transactions.

Decomposition:
- Package arduino_io_pkg:
  - FSM state enum (IDLE, SETUP, CLK_HI, CLK_LO, CAPTURE, CLEANUP, RELEASE).
  - hdr_bytes() function.
  - Constant READ_FILL = 8'hFF.
- Sub-module arduino_io_sync: SYNC_STAGES synchroniser with rising-edge pulse output; instanced twice (clock, commit).

Test Plan:
1. Write: shift 0x01, 0x23, 0xA5 (bank 0, addr 0x0123), commit with rw=1. Then read: shift 0x01, 0x23, commit rw=0. Expect:
   - mem_wre[0] pulse with mem_ad = 0x0123, mem_din = 0xA5.
   - dataout = 0xA5 at N+5.
   - Only bank-0 strobes toggle.
2. Wrap: write bank 3 addr 0x3FFF (bytes 0xFF, 0xFF, 0x5A), then autoinc write with byte 0x77. Expect the second write at bank 3, addr 0x0000; bank 3 reads 0x5A at 0x3FFF and 0x77 at 0x0000.
3. Autoinc read burst: preload bank 1 addrs 0x0010..0x0013 with 0x10..0x13; header read at 0x0010, then three autoinc reads. Expect dataout sequence 0x10, 0x11, 0x12, 0x13.
4. Busy handshake: pulse arduino_clock with byte 0xEE while busy, and hold commit high past CLEANUP. Expect:
   - Shift register unchanged.
   - Busy stays high until commit falls.
   - No second transaction.
5. Reset mid-op: assert arduino_reset during CLK_HI of a write. Expect all mem_* = 0 and busy = 0 within the same cycle (asynchronous); the pointer then reads 0.
6. NUM_BANKS=3 build: read with bank select 3. Expect no ce/oce/clk activity on any bank and dataout = 0xFF.
